// File: rtl/memory_burst.sv
// Purpose: single-port synchronous memory with a burst command port (1..2^LEN_SIZE beats per command).
// Latency: first read beat 1 cycle after command accept, then 1 beat/cycle; writes take 1 beat/cycle.
// Backpressure: ready only in IDLE; wready for the whole write burst; rready stalls reads with rdata/rlast held.
//
// Ports:
//   clk, rst                 clock (rising edge) and asynchronous active-low reset
//   valid/ready              command handshake; wr_rd, addr, len sampled on accept
//   wvalid/wready            write beat handshake; wdata + wstrb (per-byte enables)
//   rvalid/rready            read beat handshake; rdata (registered), rlast on final beat
//
// `mem` is a plain unpacked array and is never reset, so hierarchical
// backdoor load/dump access keeps working.
module memory_burst #(
    parameter int DEPTH     = 512,
    parameter int WIDTH     = 16,
    parameter int ADDR_SIZE = 9,
    parameter int LEN_SIZE  = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    output logic                 ready,
    input  logic                 wr_rd,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [LEN_SIZE-1:0]  len,
    input  logic                 wvalid,
    output logic                 wready,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [WIDTH/8-1:0]   wstrb,
    output logic                 rvalid,
    input  logic                 rready,
    output logic [WIDTH-1:0]     rdata,
    output logic                 rlast
);

    localparam int NBYTES = WIDTH / 8;
    localparam logic [ADDR_SIZE-1:0] LAST_PTR = ADDR_SIZE'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [ADDR_SIZE-1:0] ptr;
    logic [ADDR_SIZE-1:0] start_ptr;
    // Beats remaining after the current one.
    logic [LEN_SIZE-1:0]  cnt;

    logic cmd_acc;   // command accepted this edge
    logic wr_beat;   // write beat accepted this edge
    logic rd_adv;    // read beat consumed, more to come
    logic rd_done;   // final read beat consumed

    // Out-of-range start addresses fold back into the array.
    assign start_ptr = ADDR_SIZE'(32'(addr) % 32'(DEPTH));

    // Wrap explicitly at DEPTH-1 so non-power-of-two depths behave.
    function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] p);
        return (p == LAST_PTR) ? '0 : p + ADDR_SIZE'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        wready    = 1'b0;
        cmd_acc   = 1'b0;
        wr_beat   = 1'b0;
        rd_adv    = 1'b0;
        rd_done   = 1'b0;
        case (state)
            IDLE: begin
                // Gating with rst keeps ready low for the whole reset assertion.
                ready = rst;
                if (valid && rst) begin
                    cmd_acc   = 1'b1;
                    state_nxt = wr_rd ? WRITE : READ;
                end
            end
            WRITE: begin
                wready = 1'b1;
                if (wvalid) begin
                    wr_beat = 1'b1;
                    if (cnt == '0) state_nxt = IDLE;
                end
            end
            READ: begin
                if (rvalid && rready) begin
                    if (rlast) begin
                        rd_done   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        rd_adv = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr    <= '0;
            cnt    <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
            rlast  <= 1'b0;
        end else begin
            if (cmd_acc) begin
                cnt <= len;
                if (wr_rd) begin
                    ptr <= start_ptr;
                end else begin
                    // Read issues its first beat straight from the command so
                    // rvalid rises one cycle after accept; ptr runs one ahead.
                    rdata  <= mem[start_ptr];
                    ptr    <= ptr_inc(start_ptr);
                    rvalid <= 1'b1;
                    rlast  <= (len == '0);
                end
            end else if (wr_beat) begin
                ptr <= ptr_inc(ptr);
                cnt <= cnt - LEN_SIZE'(1);
            end else if (rd_adv) begin
                rdata <= mem[ptr];
                ptr   <= ptr_inc(ptr);
                cnt   <= cnt - LEN_SIZE'(1);
                rlast <= (cnt == LEN_SIZE'(1));
            end else if (rd_done) begin
                rvalid <= 1'b0;
                rlast  <= 1'b0;
            end
        end
    end

    // Storage has no reset so contents survive rst and stay backdoor-loadable.
    always_ff @(posedge clk) begin
        if (wr_beat) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (wstrb[k]) mem[ptr][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_memory_burst.sv
module tb_memory_burst;
  localparam int DEPTH     = 512;
  localparam int WIDTH     = 16;
  localparam int ADDR_SIZE = 9;
  localparam int LEN_SIZE  = 9;
  localparam int NB        = WIDTH / 8;

  logic                 clk    = 1'b0;
  logic                 rst    = 1'b0;
  logic                 valid  = 1'b0;
  logic                 wr_rd  = 1'b0;
  logic [ADDR_SIZE-1:0] addr   = '0;
  logic [LEN_SIZE-1:0]  len    = '0;
  logic                 wvalid = 1'b0;
  logic [WIDTH-1:0]     wdata  = '0;
  logic [NB-1:0]        wstrb  = '0;
  logic                 rready = 1'b0;
  logic                 ready, wready, rvalid, rlast;
  logic [WIDTH-1:0]     rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference memory: what every location must hold after the bursts so far.
  logic [WIDTH-1:0] model [DEPTH];

  typedef struct {
    int           waddr;
    logic [15:0]  wdata;
    logic [1:0]   wstrb;
    int           raddr;
    logic [15:0]  exp;
  } vec_t;

  always #5 clk = ~clk;

  memory_burst #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_SIZE(ADDR_SIZE), .LEN_SIZE(LEN_SIZE)
  ) dut (
    .clk(clk), .rst(rst),
    .valid(valid), .ready(ready), .wr_rd(wr_rd), .addr(addr), .len(len),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command, wait (bounded) for ready, return just after the accept edge.
  task automatic do_cmd(input bit w, input int a, input int l);
    int waitc = 0;
    valid = 1'b1;
    wr_rd = w;
    addr  = ADDR_SIZE'(a);
    len   = LEN_SIZE'(l);
    while (!ready && waitc < 200) begin
      step();
      waitc++;
    end
    if (waitc >= 200) check("cmd_ready_timeout", 32'(ready), 1);
    step();
    valid = 1'b0;
  endtask

  task automatic model_write(input int p, input logic [WIDTH-1:0] d, input logic [NB-1:0] s);
    for (int k = 0; k < NB; k++)
      if (s[k]) model[p][8*k +: 8] = d[8*k +: 8];
  endtask

  task automatic write_burst(input int a, input int l, input logic [WIDTH-1:0] d[$],
                             input logic [NB-1:0] s[$], input bit gaps);
    int p = a % DEPTH;
    int i = 0;
    int guard = 0;
    do_cmd(1'b1, a, l);
    while (i <= l && guard < 4 * (l + 1) + 20) begin
      check("wr_wready", 32'(wready), 1);
      if (gaps && $urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
      end else begin
        wvalid = 1'b1;
        wdata  = d[i];
        wstrb  = s[i];
        model_write(p, d[i], s[i]);
        p = (p + 1) % DEPTH;
        i++;
      end
      step();
      guard++;
    end
    wvalid = 1'b0;
    if (i <= l) check("wr_timeout", 32'(i), 32'(l + 1));
    check("wr_done_wready", 32'(wready), 0);
    check("wr_done_ready", 32'(ready), 1);
  endtask

  // Every presented beat is compared with the model; a stalled beat is
  // re-compared each cycle, which checks it holds stable.
  task automatic read_burst(input int a, input int l, input int stall_beat,
                            input int stall_n, input bit rnd);
    int beat = 0;
    int stalled = 0;
    int guard = 0;
    int p;
    do_cmd(1'b0, a, l);
    while (beat <= l && guard < 4 * (l + 1) + stall_n + 20) begin
      p = (a + beat) % DEPTH;
      check("rd_rvalid", 32'(rvalid), 1);
      check("rd_rdata", 32'(rdata), 32'(model[p]));
      check("rd_rlast", 32'(rlast), 32'(beat == l));
      if (beat == stall_beat && stalled < stall_n) begin
        rready = 1'b0;
        stalled++;
      end else if (rnd) begin
        rready = ($urandom_range(0, 2) != 0);
      end else begin
        rready = 1'b1;
      end
      step();
      guard++;
      if (rready) beat++;
    end
    rready = 1'b0;
    if (beat <= l) check("rd_timeout", 32'(beat), 32'(l + 1));
    check("rd_done_rvalid", 32'(rvalid), 0);
    check("rd_done_ready", 32'(ready), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] dq[$];
    logic [NB-1:0]    sq[$];
    vec_t vecs[6];

    vecs[0] = '{waddr: 10,  wdata: 16'hABCD, wstrb: 2'b11, raddr: 10,  exp: 16'hABCD};
    vecs[1] = '{waddr: 10,  wdata: 16'h1234, wstrb: 2'b01, raddr: 10,  exp: 16'hAB34};
    vecs[2] = '{waddr: 10,  wdata: 16'h5678, wstrb: 2'b00, raddr: 10,  exp: 16'hAB34};
    vecs[3] = '{waddr: 10,  wdata: 16'h9900, wstrb: 2'b10, raddr: 10,  exp: 16'h9934};
    vecs[4] = '{waddr: 511, wdata: 16'hBEEF, wstrb: 2'b11, raddr: 511, exp: 16'hBEEF};
    vecs[5] = '{waddr: 511, wdata: 16'h0042, wstrb: 2'b10, raddr: 511, exp: 16'h00EF};

    // Reset state
    #12;
    check("rst_ready", 32'(ready), 0);
    check("rst_wready", 32'(wready), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_rlast", 32'(rlast), 0);
    check("rst_rdata", 32'(rdata), 0);
    rst = 1'b1;
    #1;
    check("rst_release_ready", 32'(ready), 1);

    // Fill the whole array with one maximum-length burst so every later read is defined.
    dq = {};
    sq = {};
    for (int i = 0; i < DEPTH; i++) begin
      dq.push_back(WIDTH'($urandom));
      sq.push_back('1);
    end
    write_burst(0, DEPTH - 1, dq, sq, 1'b0);
    read_burst(0, DEPTH - 1, -1, 0, 1'b1);

    // Basic 4-beat write then read
    dq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    sq = '{2'b11, 2'b11, 2'b11, 2'b11};
    write_burst(0, 3, dq, sq, 1'b0);
    read_burst(0, 3, -1, 0, 1'b0);

    // Backpressure: beat 1 (2222) stalled for 3 cycles
    read_burst(0, 3, 1, 3, 1'b0);

    // Byte strobes, table driven
    for (int v = 0; v < 6; v++) begin
      dq = {};
      sq = {};
      dq.push_back(vecs[v].wdata);
      sq.push_back(vecs[v].wstrb);
      write_burst(vecs[v].waddr, 0, dq, sq, 1'b0);
      do_cmd(1'b0, vecs[v].raddr, 0);
      check("vec_rvalid", 32'(rvalid), 1);
      check("vec_rdata", 32'(rdata), 32'(vecs[v].exp));
      check("vec_rlast", 32'(rlast), 1);
      rready = 1'b1;
      step();
      rready = 1'b0;
      check("vec_rvalid_drop", 32'(rvalid), 0);
    end

    // Wrap across the top of the array
    dq = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
    sq = '{2'b11, 2'b11, 2'b11, 2'b11};
    write_burst(510, 3, dq, sq, 1'b0);
    read_burst(510, 3, -1, 0, 1'b0);
    read_burst(0, 1, -1, 0, 1'b0);

    // Reset in the middle of a write burst
    dq = {};
    sq = {};
    for (int i = 0; i < 8; i++) begin
      dq.push_back(WIDTH'(16'hC000 + i));
      sq.push_back('1);
    end
    write_burst(20, 7, dq, sq, 1'b0);
    do_cmd(1'b1, 20, 7);
    wvalid = 1'b1;
    wstrb  = '1;
    wdata  = 16'hD000;
    model_write(20, wdata, wstrb);
    step();
    wdata  = 16'hD001;
    model_write(21, wdata, wstrb);
    step();
    wdata  = 16'hD002;
    #2 rst = 1'b0;
    #1;
    check("midrst_wready", 32'(wready), 0);
    check("midrst_ready", 32'(ready), 0);
    check("midrst_rvalid", 32'(rvalid), 0);
    step();
    step();
    wvalid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_release_ready", 32'(ready), 1);
    read_burst(20, 7, -1, 0, 1'b0);
    read_burst(20, 1, -1, 0, 1'b0);

    // Command held during an active write: accepted on the first ready cycle
    do_cmd(1'b1, 30, 3);
    valid = 1'b1;
    wr_rd = 1'b0;
    addr  = ADDR_SIZE'(30);
    len   = '0;
    for (int i = 0; i < 4; i++) begin
      check("busy_ready", 32'(ready), 0);
      wvalid = 1'b1;
      wdata  = WIDTH'(16'hE000 + i);
      wstrb  = '1;
      model_write(30 + i, wdata, wstrb);
      step();
    end
    wvalid = 1'b0;
    check("busy_ready_back", 32'(ready), 1);
    step();
    valid = 1'b0;
    check("busy_rvalid", 32'(rvalid), 1);
    check("busy_rlast", 32'(rlast), 1);
    check("busy_rdata", 32'(rdata), 32'(model[30]));
    rready = 1'b1;
    step();
    rready = 1'b0;
    check("busy_rvalid_drop", 32'(rvalid), 0);
    check("busy_idle_ready", 32'(ready), 1);

    // Randomized bursts against the reference memory
    for (int t = 0; t < 40; t++) begin
      int a;
      int l;
      a = $urandom_range(0, DEPTH - 1);
      l = ($urandom_range(0, 7) == 0) ? $urandom_range(0, (1 << LEN_SIZE) - 1) : $urandom_range(0, 12);
      if ($urandom_range(0, 1) == 1) begin
        dq = {};
        sq = {};
        for (int i = 0; i <= l; i++) begin
          dq.push_back(WIDTH'($urandom));
          sq.push_back(NB'($urandom));
        end
        write_burst(a, l, dq, sq, 1'b1);
      end else begin
        read_burst(a, l, -1, 0, 1'b1);
      end
    end
    read_burst(0, DEPTH - 1, -1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_burst.md
Name: memory_burst

Overview:
Parametrised single-port synchronous memory with valid/ready command handshake and burst transfers. One accepted command moves 1..2^LEN_SIZE beats from a start address. Write beats carry per-byte strobes. Read beats have rready backpressure. Successor to the single-beat memory; sits behind the same bench-style master and keeps a plain `mem` array, so hierarchical `$readmemh`/`$writememb` backdoor access still works.

Parameters:
DEPTH, 512, number of WIDTH-bit words in `mem`.
WIDTH, 16, data width in bits; must be a multiple of 8.
ADDR_SIZE, 9, address width; 2^ADDR_SIZE >= DEPTH.
LEN_SIZE, 9, burst length field width; burst beats = len+1.

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
valid  in  1  command valid
ready  out  1  command accept; high only in IDLE
wr_rd  in  1  1 = write burst, 0 = read burst; sampled with the command
addr  in  ADDR_SIZE  burst start address
len  in  LEN_SIZE  beats minus one
wvalid  in  1  write beat valid
wready  out  1  write beat accept
wdata  in  WIDTH  write beat data
wstrb  in  WIDTH/8  byte enables; bit k enables wdata[8k+7:8k]
rvalid  out  1  read beat valid
rready  in  1  read beat accept
rdata  out  WIDTH  read beat data, registered
rlast  out  1  high with the final read beat

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; ready=0 while rst=0; wready=0, rvalid=0, rlast=0, rdata=0.
  - Internal pointer and count cleared.
  - `mem` contents are NOT cleared.
- FSM states: IDLE, WRITE, READ.
- Command handshake:
  - ready = (state==IDLE) && rst.
  - A command is accepted on a rising edge with valid && ready.
  - On accept, latch ptr=addr (reduced mod DEPTH if addr >= DEPTH), cnt=len, and go to WRITE or READ per wr_rd.
  - valid while ready=0 is ignored, not queued; the master holds valid until accepted.
- WRITE:
  - wready=1 throughout the state.
  - Each edge with wvalid && wready writes mem[ptr], byte lane k only where wstrb[k]=1; other lanes are unchanged.
  - Then ptr advances, and cnt decrements.
  - When a beat is accepted with cnt==0, return to IDLE; ready is high the next cycle.
- READ:
  - On the accept edge, rdata<=mem[addr], rvalid<=1 (first beat visible one cycle after accept), rlast<=(len==0).
  - On each edge with rvalid && rready:
    - if rlast, then rvalid<=0, rlast<=0, go to IDLE;
    - else load the next location into rdata and decrement cnt, with no bubble (one beat per cycle);
    - rlast<=1 when loading the final beat.
  - While rvalid && !rready, rdata and rlast hold stable.
- Pointer advance: ptr_next = (ptr==DEPTH-1) ? 0 : ptr+1, i.e. wrap to 0 for any DEPTH, power of two or not.
- Burst longer than DEPTH: continues wrapping; later beats overwrite earlier ones (write) or repeat data (read).
- No concurrency: a read burst never observes a write in flight, since only one burst is active at a time.
- Reset mid-burst:
  - Immediate abort: wready and rvalid fall asynchronously.
  - Beats already written remain; untouched locations keep prior values.
  - After rst returns high, ready=1 on the same cycle.
- Read latency is 1 cycle from accept to first rvalid; 1 cycle per beat after that with rready=1.
- Write throughput is 1 beat per cycle with wvalid=1.

Test Plan:
1. Write addr=0 len=3 strb=2'b11 data 16'h1111,2222,3333,4444 with wvalid held high, then read addr=0 len=3 with rready=1:
   - wready high 4 cycles;
   - rvalid rises 1 cycle after accept;
   - rdata 1111,2222,3333,4444 on consecutive cycles;
   - rlast only on 4444;
   - ready returns next cycle.
2. Byte strobes: mem[10]=16'hABCD; write addr=10 len=0 wdata=16'h1234 wstrb=2'b01 -> read returns 16'hAB34; then wstrb=2'b00 -> still 16'hAB34.
3. Wrap: write addr=510 len=3 data A0,A1,A2,A3 -> mem[510]=A0, mem[511]=A1, mem[0]=A2, mem[1]=A3; read addr=510 len=3 returns the same order.
4. Backpressure: read addr=0 len=3 with rready=0 for 3 cycles while beat 2 is presented -> rdata stays 2222 and rvalid stays 1; exactly 4 beats delivered, none dropped or duplicated.
5. Reset mid-write: write addr=20 len=7, assert rst=0 after 2 accepted beats:
   - wready=0 immediately;
   - mem[20..21] hold the new data, mem[22..27] unchanged;
   - ready=1 once rst=1;
   - a new read of addr=20 len=1 works.
6. Busy command: hold valid=1 with a new read during an active write burst -> not accepted until IDLE; accepted on the first cycle ready=1; len=0 read gives one beat with rlast=1.
